// File: rtl/eeprom_pkg.sv
// eeprom_pkg: opcodes and controller state encoding shared by the EEPROM slice
package eeprom_pkg;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_ERASE, S_PROG, S_RESP} state_e;
endpackage

// File: rtl/eeprom_if.sv
// eeprom_if: command/response handshake bundle between master and controller
interface eeprom_if #(parameter int ADDR_W = 4, parameter int DATA_W = 8);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              wp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_wdata, wp, rsp_ready,
                  input cmd_ready, rsp_valid, rsp_data, rsp_err);
  modport slave (input cmd_valid, cmd_op, cmd_addr, cmd_wdata, wp, rsp_ready,
                 output cmd_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/eeprom_array.sv
// eeprom_array: 2^ADDR_W x DATA_W storage, registered erase/program, combinational read
module eeprom_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              erase_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem_q[i] <= DATA_W'(16 + i);
    else if (erase_i) mem_q[addr_i] <= '0;
    else if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/eeprom_ctrl.sv
// eeprom_ctrl: sequences read/erase/program of the EEPROM array with timed strobes
module eeprom_ctrl import eeprom_pkg::*; #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int ERASE_CYCLES = 4,
  parameter int PROG_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  eeprom_if.slave           bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_erase,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              err_q, err_d, erase_q, erase_d, we_q, we_d, accept;
  assign accept = bus.cmd_valid && state_q == S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      erase_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      erase_q <= erase_d;
      we_q    <= we_d;
    end
  // wp is only consulted here, at accept; later changes cannot affect the op
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.cmd_valid)
                 state_d = (bus.cmd_op == OP_RSVD || (bus.cmd_op != OP_READ && bus.wp)) ? S_RESP :
                           bus.cmd_op == OP_READ ? S_READ : S_ERASE;
      S_READ:  state_d = S_RESP;
      S_ERASE: if (cnt_q == 8'd0) state_d = op_q == OP_WRITE ? S_PROG : S_RESP;
      S_PROG:  if (cnt_q == 8'd0) state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // strobes are registered from the next state so they align with state entry
  always_comb begin
    cnt_d   = state_d != state_q ? (state_d == S_PROG ? 8'(PROG_CYCLES - 1) : 8'(ERASE_CYCLES - 1))
                                 : cnt_q - 8'd1;
    op_d    = accept ? bus.cmd_op : op_q;
    addr_d  = accept ? bus.cmd_addr : addr_q;
    wdata_d = accept ? bus.cmd_wdata : wdata_q;
    err_d   = accept ? state_d == S_RESP : err_q;
    rdata_d = accept ? '0 : state_q == S_READ ? mem_rdata : rdata_q;
    erase_d = state_d == S_ERASE;
    we_d    = state_d == S_PROG;
  end
  assign bus.cmd_ready = state_q == S_IDLE;
  assign bus.rsp_valid = state_q == S_RESP;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_err   = err_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_erase     = erase_q;
  assign mem_we        = we_q;
endmodule

// File: tb/tb_eeprom_ctrl.sv
// tb_eeprom_ctrl: directed checks of eeprom_ctrl driving an eeprom_array
module tb_eeprom_ctrl;
  import eeprom_pkg::*;
  logic clk, rst_n;
  logic [3:0] mem_addr;
  logic mem_erase, mem_we;
  logic [7:0] mem_wdata, mem_rdata;
  logic [31:0] er_h, we_h, rv_h, rdy_h;
  logic [7:0] r_data;
  logic r_err;
  int nerr = 0, nchk = 0;

  eeprom_if #(.ADDR_W(4), .DATA_W(8)) bus();
  eeprom_ctrl #(.ADDR_W(4), .DATA_W(8), .ERASE_CYCLES(4), .PROG_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .mem_addr(mem_addr), .mem_erase(mem_erase),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
  eeprom_array #(.ADDR_W(4), .DATA_W(8)) arr (
    .clk(clk), .rst_n(rst_n), .addr_i(mem_addr), .erase_i(mem_erase), .we_i(mem_we),
    .wdata_i(mem_wdata), .rdata_o(mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bit k of each history is the value seen in cycle k after the accept edge
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                         input logic w, input int n);
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = d; bus.wp = w; bus.cmd_valid = 1'b1;
    chk("accept_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0; bus.wp = ~w;
    er_h = '0; we_h = '0; rv_h = '0; rdy_h = '0; r_data = 8'hEE; r_err = 1'bx;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      er_h[k] = mem_erase; we_h[k] = mem_we; rv_h[k] = bus.rsp_valid; rdy_h[k] = bus.cmd_ready;
      if (bus.rsp_valid) begin r_data = bus.rsp_data; r_err = bus.rsp_err; end
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_op = OP_READ; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.wp = 1'b0; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_strobes", {30'd0, mem_erase, mem_we}, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    run_cmd(OP_READ, 4'd3, 8'h00, 1'b0, 3);
    chk("rd3_rv", rv_h, 32'h4);
    chk("rd3_rdy", rdy_h, 32'h8);
    chk("rd3_strobes", er_h | we_h, 32'h0);
    chk("rd3_data", 32'(r_data), 32'h13);
    chk("rd3_err", 32'(r_err), 32'd0);

    run_cmd(OP_WRITE, 4'd5, 8'hA7, 1'b0, 10);
    chk("wr5_erase", er_h, 32'h1E);
    chk("wr5_we", we_h, 32'h1E0);
    chk("wr5_rv", rv_h, 32'h200);
    chk("wr5_rdy", rdy_h, 32'h400);
    chk("wr5_err", 32'(r_err), 32'd0);
    chk("wr5_data", 32'(r_data), 32'd0);
    run_cmd(OP_READ, 4'd5, 8'h00, 1'b0, 3);
    chk("rd5_data", 32'(r_data), 32'hA7);

    run_cmd(OP_ERASE, 4'd15, 8'h5A, 1'b0, 6);
    chk("er15_erase", er_h, 32'h1E);
    chk("er15_we", we_h, 32'h0);
    chk("er15_rv", rv_h, 32'h20);
    chk("er15_err", 32'(r_err), 32'd0);
    run_cmd(OP_READ, 4'd15, 8'h00, 1'b0, 3);
    chk("rd15_data", 32'(r_data), 32'h00);

    run_cmd(OP_WRITE, 4'd2, 8'h55, 1'b1, 2);
    chk("wpw_rv", rv_h, 32'h2);
    chk("wpw_rdy", rdy_h, 32'h4);
    chk("wpw_strobes", er_h | we_h, 32'h0);
    chk("wpw_err", 32'(r_err), 32'd1);
    run_cmd(OP_READ, 4'd2, 8'h00, 1'b0, 3);
    chk("rd2_data", 32'(r_data), 32'h12);

    run_cmd(OP_ERASE, 4'd6, 8'h00, 1'b1, 2);
    chk("wpe_rv", rv_h, 32'h2);
    chk("wpe_strobes", er_h | we_h, 32'h0);
    chk("wpe_err", 32'(r_err), 32'd1);
    run_cmd(OP_READ, 4'd6, 8'h00, 1'b0, 3);
    chk("rd6_data", 32'(r_data), 32'h16);

    run_cmd(OP_RSVD, 4'd4, 8'h99, 1'b0, 2);
    chk("rsvd_rv", rv_h, 32'h2);
    chk("rsvd_strobes", er_h | we_h, 32'h0);
    chk("rsvd_err", 32'(r_err), 32'd1);
    chk("rsvd_data", 32'(r_data), 32'd0);
    run_cmd(OP_READ, 4'd4, 8'h00, 1'b0, 3);
    chk("rd4_data", 32'(r_data), 32'h14);

    bus.rsp_ready = 1'b0;
    run_cmd(OP_READ, 4'd7, 8'h00, 1'b0, 7);
    chk("hold_rv", rv_h, 32'hFC);
    chk("hold_rdy", rdy_h, 32'h0);
    chk("hold_data", 32'(bus.rsp_data), 32'h17);
    chk("hold_err", 32'(bus.rsp_err), 32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rel_rv", 32'(bus.rsp_valid), 32'd0);
    run_cmd(OP_READ, 4'd8, 8'h00, 1'b0, 3);
    chk("rd8_data", 32'(r_data), 32'h18);

    run_cmd(OP_WRITE, 4'd9, 8'h3C, 1'b0, 6);
    chk("wr9_erase", er_h, 32'h1E);
    chk("wr9_we", we_h, 32'h60);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we), 32'd0);
    chk("arst_erase", 32'(mem_erase), 32'd0);
    chk("arst_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_rv", 32'(bus.rsp_valid), 32'd0);
      chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    end
    run_cmd(OP_READ, 4'd9, 8'h00, 1'b0, 3);
    chk("rd9_data", 32'(r_data), 32'h19);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
